// File: rtl/nios2_keys_ctrl.sv
// nios2_keys_ctrl: Avalon-MM managed key interface for the Nios II system.
// Synchronises four active-low push-buttons, debounces each key independently
// and latches press events in a write-1-to-clear edge-capture register.
// Optional feature macro: NIOS2_KEYS_CTRL_IRQ_EN
//   defined   -> MASK register at address 1 and a maskable level irq
//   undefined -> address 1 reads 0, writes to it are ignored, irq tied to 0
//
// Register map:
//   0 DATA        (RO)  {28'b0, debounced keys}
//   1 MASK        (RW)  mask[3:0]
//   2 reserved          reads 0, writes ignored
//   3 EDGECAPTURE (W1C) edgecap[3:0]
module nios2_keys_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  in_port,
    output logic [31:0] readdata,
    output logic        irq
);

    localparam int unsigned       CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]     CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_MASK    = 2'd1;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    logic [3:0]    s1;
    logic [3:0]    s2;
    logic [3:0]    db;
    logic [CW-1:0] cnt [4];
    logic [3:0]    press;
    logic [3:0]    edgecap;
    logic [3:0]    mask;
    logic [3:0]    ec_clr;

    // Upper write-data bits carry no register state.
    logic unused_wdata;
    assign unused_wdata = ^writedata[31:4];

    // Two-flop synchroniser; resets to "all released" so no press follows reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= '1;
            s2 <= '1;
        end else begin
            s1 <= in_port;
            s2 <= s1;
        end
    end

    // Per-key debounce: db follows s2 only after DEBOUNCE_CYCLES stable cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            db <= '1;
            for (int unsigned i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (s2[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    db[i]  <= s2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    // Press event: db about to change from released (1) to pressed (0).
    always_comb begin
        press = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            press[i] = db[i] && !s2[i] && (cnt[i] == CNT_LAST);
        end
    end

    // W1C clear mask for the edge-capture register.
    always_comb begin
        ec_clr = '0;
        if (write && (address == ADDR_EDGECAP)) begin
            ec_clr = writedata[3:0];
        end
    end

    // Edge capture: a press in the same cycle as its clear keeps the bit set.
    always_ff @(posedge clk) begin
        if (reset) begin
            edgecap <= '0;
        end else begin
            edgecap <= (edgecap & ~ec_clr) | press;
        end
    end

`ifdef NIOS2_KEYS_CTRL_IRQ_EN
    // Interrupt mask register.
    always_ff @(posedge clk) begin
        if (reset) begin
            mask <= '0;
        end else if (write && (address == ADDR_MASK)) begin
            mask <= writedata[3:0];
        end
    end

    assign irq = |(edgecap & mask);
`else
    assign mask = '0;
    assign irq  = 1'b0;
`endif

    // Registered read mux; reads have no side effects and see pre-write state.
    always_ff @(posedge clk) begin
        if (reset) begin
            readdata <= '0;
        end else begin
            case (address)
                ADDR_DATA:    readdata <= {28'b0, db};
                ADDR_MASK:    readdata <= {28'b0, mask};
                ADDR_EDGECAP: readdata <= {28'b0, edgecap};
                default:      readdata <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_nios2_keys_ctrl.sv
// tb_nios2_keys_ctrl: directed self-checking bench for nios2_keys_ctrl
// with DEBOUNCE_CYCLES = 4. Expectations follow NIOS2_KEYS_CTRL_IRQ_EN.
module tb_nios2_keys_ctrl;

    logic        clk;
    logic        reset;
    logic [1:0]  address;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  in_port;
    logic [31:0] readdata;
    logic        irq;

    int n_checks;
    int n_fail;

`ifdef NIOS2_KEYS_CTRL_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    nios2_keys_ctrl #(
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .write     (write),
        .writedata (writedata),
        .in_port   (in_port),
        .readdata  (readdata),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address   = a;
        writedata = d;
        write     = 1'b1;
        tick(1);
        write     = 1'b0;
        writedata = '0;
    endtask

    task automatic rd(input logic [1:0] a, input string tag, input logic [31:0] exp);
        address = a;
        tick(1);
        check(tag, readdata, exp);
    endtask

    initial begin
        clk       = 1'b0;
        reset     = 1'b1;
        in_port   = 4'h0;
        address   = 2'd0;
        write     = 1'b0;
        writedata = '0;
        n_checks  = 0;
        n_fail    = 0;

        // 1. Reset with keys held low
        tick(1);
        check("rst_rdata_e1", readdata, 32'h0);
        check("rst_irq_e1", {31'b0, irq}, 32'h0);
        tick(1);
        check("rst_rdata_e2", readdata, 32'h0);
        reset = 1'b0;
        rd(2'd0, "post_rst_data", 32'hF);
        rd(2'd3, "post_rst_ec", 32'h0);
        // reset again mid-debounce, keys released: count discarded, no event
        reset   = 1'b1;
        in_port = 4'hF;
        tick(2);
        reset = 1'b0;
        tick(10);
        rd(2'd3, "rst_mid_ec", 32'h0);
        rd(2'd0, "rst_mid_data", 32'hF);

        // 2. Clean press of key1: db updates on edge 6, DATA visible edge 7
        address = 2'd0;
        in_port = 4'hD;
        tick(5);
        check("press_e5", readdata, 32'hF);
        tick(1);
        check("press_e6", readdata, 32'hF);
        check("press_e6_irq", {31'b0, irq}, 32'h0);
        tick(1);
        check("press_e7", readdata, 32'hD);
        rd(2'd3, "press_ec", 32'h2);
        address = 2'd0;
        in_port = 4'hF;
        tick(7);
        check("release_data", readdata, 32'hF);
        rd(2'd3, "release_ec", 32'h2);
        wr(2'd3, 32'h2);
        rd(2'd3, "ec_cleared", 32'h0);

        // 3. Bounce on key0 then hold pressed
        address = 2'd0;
        for (int p = 0; p < 6; p++) begin
            in_port = (p % 2 == 0) ? 4'hE : 4'hF;
            tick(1);
            check("bounce_data", readdata, 32'hF);
            tick(1);
            check("bounce_data", readdata, 32'hF);
        end
        in_port = 4'hE;
        for (int k = 1; k <= 6; k++) begin
            tick(1);
            check("settle_data", readdata, 32'hF);
        end
        tick(1);
        check("settled_data", readdata, 32'hE);
        rd(2'd3, "bounce_ec", 32'h1);
        wr(2'd3, 32'h0);
        rd(2'd3, "w1c_zero", 32'h1);
        in_port = 4'hF;
        tick(8);
        wr(2'd3, 32'h1);
        rd(2'd3, "bounce_ec_clr", 32'h0);

        // 4. Interrupt and clear, plus set/clear collision
        wr(2'd1, 32'h2);
        rd(2'd1, "mask_rd", IRQ_EN ? 32'h2 : 32'h0);
        in_port = 4'hD;
        tick(5);
        check("irq_e5", {31'b0, irq}, 32'h0);
        tick(1);
        check("irq_e6", {31'b0, irq}, IRQ_EN ? 32'h1 : 32'h0);
        wr(2'd3, 32'h2);
        check("irq_cleared", {31'b0, irq}, 32'h0);
        rd(2'd3, "ec_w1c", 32'h0);
        in_port = 4'hF;
        tick(8);
        in_port = 4'hD;
        tick(5);
        wr(2'd3, 32'h2);
        check("collide_irq", {31'b0, irq}, IRQ_EN ? 32'h1 : 32'h0);
        rd(2'd3, "collide_ec", 32'h2);
        in_port = 4'hF;
        tick(8);
        wr(2'd3, 32'h2);
        rd(2'd3, "collide_clr", 32'h0);

        // 5. Mask gating with simultaneous presses on keys 2 and 3
        wr(2'd1, 32'h0);
        in_port = 4'h3;
        tick(7);
        rd(2'd3, "multi_ec", 32'hC);
        check("multi_irq_masked", {31'b0, irq}, 32'h0);
        wr(2'd1, 32'h4);
        check("multi_irq_unmask", {31'b0, irq}, IRQ_EN ? 32'h1 : 32'h0);
        in_port = 4'hF;
        tick(8);
        wr(2'd3, 32'hC);
        rd(2'd3, "multi_clr", 32'h0);

        // 6. Full mask write, reserved address, key0 press
        wr(2'd1, 32'hF);
        rd(2'd1, "mask_full", IRQ_EN ? 32'hF : 32'h0);
        wr(2'd2, 32'hFFFF_FFFF);
        rd(2'd2, "reserved_rd", 32'h0);
        in_port = 4'hE;
        tick(7);
        rd(2'd3, "key0_ec", 32'h1);
        check("key0_irq", {31'b0, irq}, IRQ_EN ? 32'h1 : 32'h0);
        rd(2'd0, "key0_data", 32'hE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
